// File: rtl/div_restoring_ctrl_if.sv
// div_restoring_ctrl_if
// Start/done bus of the sequential restoring divider.
//   start        : requester -> divider, request (only looked at while idle)
//   A, B         : requester -> divider, dividend / divisor (n bits)
//   busy         : divider -> requester, high while a quotient is being built
//   done         : divider -> requester, one-cycle result strobe
//   div_by_zero  : divider -> requester, B was zero (valid with done, held)
//   Q, R         : divider -> requester, quotient / remainder (held)
// Handshake: start acts as "valid" and the divider being idle acts as
// "ready"; a request transfers on the rising edge where start=1 and the
// divider is idle, and A/B are captured on that same edge. Requests made
// while the divider is busy or presenting done are dropped, not queued.
// done is a single-cycle strobe with no back-pressure; Q/R/div_by_zero stay
// valid from that cycle until the next result.
interface div_restoring_ctrl_if #(
  parameter int n = 4
);
  logic         start;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [n-1:0] Q;
  logic [n-1:0] R;

  modport master (
    output start, A, B,
    input  busy, done, div_by_zero, Q, R
  );

  modport slave (
    input  start, A, B,
    output busy, done, div_by_zero, Q, R
  );
endinterface

// File: rtl/div_restoring_ctrl.sv
// div_restoring_ctrl
// Sequential unsigned restoring divider: Q = A / B, R = A % B.
// One quotient bit is resolved per clock through a single (n+2)-bit
// subtract stage, so a division takes n cycles in CALC plus one DONE cycle.
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous, active-high reset
//   bus          : start/done interface (slave side), see div_restoring_ctrl_if
//   dbg_state_o  : current FSM state (0 IDLE, 1 CALC, 2 DONE)
module div_restoring_ctrl #(
  parameter int n = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  div_restoring_ctrl_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(n + 1);

  logic [1:0]    state_q, state_d;
  logic [n-1:0]  d_q, d_d;      // dividend shifts out MSB-first, quotient shifts in
  logic [n-1:0]  v_q, v_d;      // latched divisor
  logic [n-1:0]  p_q, p_d;      // partial remainder
  logic [CW-1:0] cnt_q, cnt_d;  // quotient bits still to resolve
  logic [n-1:0]  quo_q, quo_d;
  logic [n-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;

  // Shared subtract stage
  logic [n:0]    t;
  logic [n+1:0]  s;
  logic          accept;
  logic [n-1:0]  p_step;
  logic [n-1:0]  d_step;

  assign t = {p_q, d_q[n-1]};
  assign s = {1'b0, t} - {2'b0, v_q};
  // The trial is accepted when there is no borrow (s[n+1]==0). Because
  // P < V always holds, an accepted difference is below V, so s[n] is
  // necessarily 0 whenever s[n+1] is 0; including it keeps the test exact.
  assign accept = ~(s[n+1] | s[n]);
  assign p_step = accept ? s[n-1:0] : t[n-1:0];
  assign d_step = {d_q[n-2:0], accept};

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.B != '0) begin
            d_d     = bus.A;
            v_d     = bus.B;
            p_d     = '0;
            cnt_d   = CW'(n);
            state_d = S_CALC;
          end else begin
            // Divide by zero short-circuits straight to the result.
            quo_d   = '1;
            rem_d   = bus.A;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        p_d   = p_step;
        d_d   = d_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = d_step;
          rem_d   = p_step;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      v_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Status decoded straight from the state register so they drop together
  // with it on an asynchronous reset.
  assign bus.busy        = (state_q == S_CALC);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = dz_q;
  assign bus.Q           = quo_q;
  assign bus.R           = rem_q;
  assign dbg_state_o     = state_q;

endmodule
